display_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver. It latches a packed multi-digit value, scans one digit at a time at a programmable refresh rate, and drives active-low anodes, segments and decimal point. Per-digit blanking, hex decode and an anti-ghosting guard interval are built in. It sits between the datapath/FSM that produces numeric results and the board's common-anode display pins, and replaces per-digit static decoders.

---
 rtl/display_scan.sv | 79 +++++++
 tb/tb_display_scan.sv | 132 +++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: multiplexed seven-segment driver with shadow/display registers, blanking, hex decode and guard interval
module display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int HEX_EN      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame_tick
);
  localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] sh_data, dsp_data;
  logic [DIGITS-1:0] sh_dp, sh_blank, dsp_dp, dsp_blank;
  logic slot_end, frame_end, dark;
  logic [3:0] nib;
  logic [6:0] dec;
  assign slot_end  = cnt == CW'(REFRESH_DIV - 1);
  assign frame_end = slot_end && idx == IW'(DIGITS - 1);
  assign nib       = dsp_data[{idx, 2'b00} +: 4];
  assign dark      = cnt < CW'(GUARD) || dsp_blank[idx];
  always_comb begin
    dec = 7'b1111111;
    case (nib)
      4'h0: dec = 7'b1000000;
      4'h1: dec = 7'b1111001;
      4'h2: dec = 7'b0100100;
      4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001;
      4'h5: dec = 7'b0010010;
      4'h6: dec = 7'b0000010;
      4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000;
      4'h9: dec = 7'b0010000;
      4'ha: dec = HEX_EN != 0 ? 7'b0001000 : 7'b1111111;
      4'hb: dec = HEX_EN != 0 ? 7'b0000011 : 7'b1111111;
      4'hc: dec = HEX_EN != 0 ? 7'b1000110 : 7'b1111111;
      4'hd: dec = HEX_EN != 0 ? 7'b0100001 : 7'b1111111;
      4'he: dec = HEX_EN != 0 ? 7'b0000110 : 7'b1111111;
      default: dec = HEX_EN != 0 ? 7'b0001110 : 7'b1111111;
    endcase
  end
  // display register only follows the shadow at a frame boundary, so a frame is never torn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      dsp_data   <= '0;
      dsp_dp     <= '0;
      dsp_blank  <= '0;
      an         <= '1;
      seg        <= '1;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (load) {sh_data, sh_dp, sh_blank} <= {data, dp, blank};
      if (frame_end) {dsp_data, dsp_dp, dsp_blank} <= {sh_data, sh_dp, sh_blank};
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      an         <= dark ? '1 : ~(DIGITS'(1) << idx);
      seg        <= dark ? 7'b1111111 : dec;
      dp_n       <= dark | ~dsp_dp[idx];
      frame_tick <= frame_end;
    end
  end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed vector table for the 4-digit, hex-off and single-digit variants of display_scan
module tb_display_scan;
  typedef struct {
    int ph;
    int k;
    int u;
    logic [3:0] an;
    logic [6:0] seg;
    logic dpn;
    logic tick;
  } vec_t;
  logic clk = 0, rst = 1, load = 0;
  logic [15:0] data = '0;
  logic [3:0] dp = '0, blank = '0;
  logic [3:0] an0, an1;
  logic [0:0] an2;
  logic [6:0] seg0, seg1, seg2;
  logic dpn0, dpn1, dpn2, tick0, tick1, tick2;
  int checks = 0, errors = 0, p = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  display_scan #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .HEX_EN(1)) u_main (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .load(load),
    .an(an0), .seg(seg0), .dp_n(dpn0), .frame_tick(tick0));
  display_scan #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .HEX_EN(0)) u_nohex (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .load(load),
    .an(an1), .seg(seg1), .dp_n(dpn1), .frame_tick(tick1));
  display_scan #(.DIGITS(1), .REFRESH_DIV(4), .GUARD(2), .HEX_EN(1)) u_one (
    .clk(clk), .rst(rst), .data(data[3:0]), .dp(dp[0:0]), .blank(blank[0:0]), .load(load),
    .an(an2), .seg(seg2), .dp_n(dpn2), .frame_tick(tick2));
  task automatic add(input int ph, k, u, input logic [3:0] a, input logic [6:0] s, input logic d, t);
    vec_t v;
    v = '{ph, k, u, a, s, d, t};
    q.push_back(v);
  endtask
  task automatic check_row(input vec_t r);
    logic [12:0] act, exp;
    act = r.u == 0 ? {an0, seg0, dpn0, tick0} : r.u == 1 ? {an1, seg1, dpn1, tick1} : {3'b111, an2, seg2, dpn2, tick2};
    exp = {r.an, r.seg, r.dpn, r.tick};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL ph%0d u%0d k%0d got an=%b seg=%b dp_n=%b tick=%b want an=%b seg=%b dp_n=%b tick=%b",
               r.ph, r.u, r.k, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask
  task automatic stim(input int k);
    load = k == 0 || k == 69 || k == 127;
    if (k == 0) {data, dp, blank} = {16'h4321, 4'b0000, 4'b0000};
    if (k == 69) data = 16'hABCD;
    if (k == 127) {data, dp, blank} = {16'hE987, 4'b0001, 4'b0100};
  endtask
  task automatic run(input int ph, input int last);
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      while (p < q.size() && q[p].ph == ph && q[p].k == k) begin
        check_row(q[p]);
        p++;
      end
      if (ph == 1) stim(k);
      else load = 0;
    end
    while (p < q.size() && q[p].ph == ph) begin
      checks++;
      errors++;
      $display("FAIL ph%0d row k%0d not reached", ph, q[p].k);
      p++;
    end
  endtask
  initial begin
    add(1, 0, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 1, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 1, 2, 4'b1111, 7'b1111111, 1, 0);
    add(1, 2, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 3, 0, 4'b1110, 7'b1000000, 1, 0);
    add(1, 3, 2, 4'b1110, 7'b1000000, 1, 0);
    add(1, 4, 2, 4'b1110, 7'b1000000, 1, 1);
    add(1, 5, 2, 4'b1111, 7'b1111111, 1, 0);
    add(1, 7, 2, 4'b1110, 7'b1111001, 1, 0);
    add(1, 32, 0, 4'b0111, 7'b1000000, 1, 1);
    add(1, 33, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 35, 0, 4'b1110, 7'b1111001, 1, 0);
    add(1, 40, 0, 4'b1110, 7'b1111001, 1, 0);
    add(1, 41, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 43, 0, 4'b1101, 7'b0100100, 1, 0);
    add(1, 51, 0, 4'b1011, 7'b0110000, 1, 0);
    add(1, 59, 0, 4'b0111, 7'b0011001, 1, 0);
    add(1, 63, 0, 4'b0111, 7'b0011001, 1, 0);
    add(1, 64, 0, 4'b0111, 7'b0011001, 1, 1);
    add(1, 91, 0, 4'b0111, 7'b0011001, 1, 0);
    add(1, 96, 0, 4'b0111, 7'b0011001, 1, 1);
    add(1, 99, 0, 4'b1110, 7'b0100001, 1, 0);
    add(1, 99, 1, 4'b1110, 7'b1111111, 1, 0);
    add(1, 99, 2, 4'b1110, 7'b0100001, 1, 0);
    add(1, 107, 0, 4'b1101, 7'b1000110, 1, 0);
    add(1, 115, 0, 4'b1011, 7'b0000011, 1, 0);
    add(1, 115, 1, 4'b1011, 7'b1111111, 1, 0);
    add(1, 123, 0, 4'b0111, 7'b0001000, 1, 0);
    add(1, 131, 0, 4'b1110, 7'b0100001, 1, 0);
    add(1, 155, 0, 4'b0111, 7'b0001000, 1, 0);
    add(1, 160, 0, 4'b0111, 7'b0001000, 1, 1);
    add(1, 160, 2, 4'b1110, 7'b1111000, 0, 1);
    add(1, 163, 0, 4'b1110, 7'b1111000, 0, 0);
    add(1, 171, 0, 4'b1101, 7'b0000000, 1, 0);
    add(1, 179, 0, 4'b1111, 7'b1111111, 1, 0);
    add(1, 187, 0, 4'b0111, 7'b0000110, 1, 0);
    add(1, 187, 1, 4'b0111, 7'b1111111, 1, 0);
    add(2, 0, 0, 4'b1111, 7'b1111111, 1, 0);
    add(2, 2, 0, 4'b1111, 7'b1111111, 1, 0);
    add(2, 3, 0, 4'b1110, 7'b1000000, 1, 0);
    add(2, 7, 2, 4'b1110, 7'b1000000, 1, 0);
    add(2, 8, 2, 4'b1110, 7'b1000000, 1, 1);
    add(2, 32, 0, 4'b0111, 7'b1000000, 1, 1);
    add(2, 35, 0, 4'b1110, 7'b1000000, 1, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    run(1, 190);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check_row('{0, -1, 0, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    check_row('{0, -1, 2, 4'b1111, 7'b1111111, 1'b1, 1'b0});
    @(negedge clk);
    rst = 0;
    run(2, 40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
